// File: rtl/icache_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : icache_pkg
//  Purpose  : Shared definitions for the direct-mapped instruction cache.
//             Holds default geometry, the refill state encoding and helpers
//             that split a byte address into word offset / index / tag.
//  Revision : 1.0  initial release
// ============================================================================
package icache_pkg;

  localparam int IC_INDEX_BITS  = 6;   // 64 lines
  localparam int IC_OFFSET_BITS = 2;   // 4 words per line
  localparam int ADDR_BITS      = 32;
  localparam int WORD_BITS      = 32;
  localparam int BYTE_BITS      = 2;   // byte-in-word bits, always ignored

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_REFILL = 1'b1;

  function automatic int tag_bits(input int index_bits, input int offset_bits);
    return ADDR_BITS - index_bits - offset_bits - BYTE_BITS;
  endfunction

  // Right-justified field of 'width' bits starting at bit 'lsb'.
  function automatic logic [31:0] addr_field(input logic [31:0] addr,
                                             input int lsb, input int width);
    logic [31:0] mask;
    mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'h1 << width) - 32'h1);
    return (addr >> lsb) & mask;
  endfunction

  function automatic logic [31:0] offset_field(input logic [31:0] addr,
                                               input int offset_bits);
    return addr_field(addr, BYTE_BITS, offset_bits);
  endfunction

  function automatic logic [31:0] index_field(input logic [31:0] addr,
                                              input int index_bits,
                                              input int offset_bits);
    return addr_field(addr, BYTE_BITS + offset_bits, index_bits);
  endfunction

  function automatic logic [31:0] tag_field(input logic [31:0] addr,
                                            input int index_bits,
                                            input int offset_bits);
    return addr_field(addr, BYTE_BITS + offset_bits + index_bits,
                      tag_bits(index_bits, offset_bits));
  endfunction

endpackage : icache_pkg
`default_nettype wire

// File: rtl/icache_line_array.sv
`default_nettype none
// ============================================================================
//  Module   : icache_line_array
//  Purpose  : Valid / tag / data storage for the direct-mapped cache.
//  Ports    : clk_in, rst_in        clock, synchronous active-high reset
//             rd_index, rd_offset   combinational read address
//             rd_valid/rd_tag/rd_word  read data for that line / word
//             wr_en, wr_index, wr_tag, wr_line  whole-line write port
//  Revision : 1.0  initial release
// ============================================================================
module icache_line_array
  import icache_pkg::*;
#(
  parameter int INDEX_BITS  = IC_INDEX_BITS,
  parameter int OFFSET_BITS = IC_OFFSET_BITS,
  parameter int TAG_BITS    = tag_bits(IC_INDEX_BITS, IC_OFFSET_BITS)
) (
  input  logic                                clk_in,
  input  logic                                rst_in,
  input  logic [INDEX_BITS-1:0]               rd_index,
  input  logic [OFFSET_BITS-1:0]              rd_offset,
  output logic                                rd_valid,
  output logic [TAG_BITS-1:0]                 rd_tag,
  output logic [WORD_BITS-1:0]                rd_word,
  input  logic                                wr_en,
  input  logic [INDEX_BITS-1:0]               wr_index,
  input  logic [TAG_BITS-1:0]                 wr_tag,
  input  logic [(WORD_BITS<<OFFSET_BITS)-1:0] wr_line
);

  localparam int LINES      = 1 << INDEX_BITS;
  localparam int LINE_WORDS = 1 << OFFSET_BITS;

  logic [LINES-1:0]                          r_valid;
  logic [TAG_BITS-1:0]                       r_tag  [LINES];
  logic [LINE_WORDS-1:0][WORD_BITS-1:0]      r_data [LINES];

  // Only the valid bits need a reset; tag/data are qualified by them.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_valid <= '0;
    end else if (wr_en) begin
      r_valid[wr_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      r_tag[wr_index]  <= wr_tag;
      r_data[wr_index] <= wr_line;
    end
  end

  assign rd_valid = r_valid[rd_index];
  assign rd_tag   = r_tag[rd_index];
  assign rd_word  = r_data[rd_index][rd_offset];

endmodule : icache_line_array
`default_nettype wire

// File: rtl/icache_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : icache_fetch
//  Purpose  : Direct-mapped instruction cache between the fetch stage and the
//             memory-interface instruction port. Hits are served in the same
//             cycle; a miss refills the whole line with sequential word reads
//             (ascending from offset 0) and the fetch then hits from the array.
//  Ports    : clk_in, rst_in, rdy_in (global stall), rob_clear (flush)
//             fetch_valid/fetch_addr -> fetch_ready/fetch_inst
//             inst_valid/inst_addr   -> inst_ready/inst_result
//  Options  : ICACHE_CRITICAL_WORD_EN - serve the missed fetch directly from
//             inst_result when its word arrives during the refill.
//  Revision : 1.0  initial release
// ============================================================================
module icache_fetch
  import icache_pkg::*;
#(
  parameter int INDEX_BITS  = IC_INDEX_BITS,
  parameter int OFFSET_BITS = IC_OFFSET_BITS
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        rob_clear,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_addr,
  output logic        fetch_ready,
  output logic [31:0] fetch_inst,
  output logic        inst_valid,
  output logic [31:0] inst_addr,
  input  logic        inst_ready,
  input  logic [31:0] inst_result
);

  localparam int TAG_BITS   = tag_bits(INDEX_BITS, OFFSET_BITS);
  localparam int LINE_BITS  = TAG_BITS + INDEX_BITS;
  localparam int LINE_WORDS = 1 << OFFSET_BITS;
  localparam logic [OFFSET_BITS-1:0] CNT_LAST = '1;
  localparam logic [OFFSET_BITS-1:0] CNT_ONE  = {{(OFFSET_BITS-1){1'b0}}, 1'b1};

  // ---------------------------------------------------------------- address
  logic [31:0]            w_off_f, w_idx_f, w_tag_f;
  logic [OFFSET_BITS-1:0] w_off;
  logic [INDEX_BITS-1:0]  w_idx;
  logic [TAG_BITS-1:0]    w_tag;
  logic                   unused_addr_bits;

  assign w_off_f = offset_field(fetch_addr, OFFSET_BITS);
  assign w_idx_f = index_field(fetch_addr, INDEX_BITS, OFFSET_BITS);
  assign w_tag_f = tag_field(fetch_addr, INDEX_BITS, OFFSET_BITS);
  assign w_off   = w_off_f[OFFSET_BITS-1:0];
  assign w_idx   = w_idx_f[INDEX_BITS-1:0];
  assign w_tag   = w_tag_f[TAG_BITS-1:0];
  // Byte-select bits and the zero-filled upper field bits carry no information.
  assign unused_addr_bits = ^{fetch_addr[1:0], w_off_f, w_idx_f, w_tag_f};

  // ---------------------------------------------------------------- state
  logic [0:0]                           r_state;
  logic [LINE_BITS-1:0]                 r_base;   // {tag, index} being refilled
  logic [OFFSET_BITS-1:0]               r_cnt;
  logic [LINE_WORDS-1:0][WORD_BITS-1:0] r_buf;

  // ---------------------------------------------------------------- array
  logic                                 w_rd_valid;
  logic [TAG_BITS-1:0]                  w_rd_tag;
  logic [WORD_BITS-1:0]                 w_rd_word;
  logic                                 w_wr_en;
  logic [LINE_WORDS-1:0][WORD_BITS-1:0] w_line;

  icache_line_array #(
    .INDEX_BITS  (INDEX_BITS),
    .OFFSET_BITS (OFFSET_BITS),
    .TAG_BITS    (TAG_BITS)
  ) u_lines (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .rd_index  (w_idx),
    .rd_offset (w_off),
    .rd_valid  (w_rd_valid),
    .rd_tag    (w_rd_tag),
    .rd_word   (w_rd_word),
    .wr_en     (w_wr_en),
    .wr_index  (r_base[INDEX_BITS-1:0]),
    .wr_tag    (r_base[LINE_BITS-1:INDEX_BITS]),
    .wr_line   (w_line)
  );

  // ---------------------------------------------------------------- control
  logic                   w_idle, w_refill, w_take, w_last, w_lookup_hit;
  logic                   w_serve_hit, w_miss, w_crit_serve;
  logic [OFFSET_BITS-1:0] w_cnt_inc, w_req_cnt;

  assign w_idle       = (r_state == ST_IDLE);
  assign w_refill     = (r_state == ST_REFILL);
  assign w_lookup_hit = w_rd_valid && (w_rd_tag == w_tag);
  // A word is accepted only when nothing stalls or cancels the cycle.
  assign w_take       = w_refill && rdy_in && inst_ready && !rob_clear;
  assign w_last       = (r_cnt == CNT_LAST);
  assign w_cnt_inc    = r_cnt + CNT_ONE;
  assign w_serve_hit  = w_idle && fetch_valid && w_lookup_hit && rdy_in && !rob_clear;
  assign w_miss       = w_idle && fetch_valid && !w_lookup_hit && rdy_in && !rob_clear;
  assign w_wr_en      = w_take && w_last;

  // The memory side samples the next request in the same cycle it returns
  // data, so the following address must already be visible on a take.
  assign w_req_cnt  = (w_take && !w_last) ? w_cnt_inc : r_cnt;
  assign inst_valid = w_refill && !rob_clear && !(w_take && w_last);
  assign inst_addr  = w_refill ? {r_base, w_req_cnt, 2'b00} : 32'h0;

  // Line written to the array: buffered words plus the one arriving now.
  always_comb begin
    w_line        = r_buf;
    w_line[r_cnt] = inst_result;
  end

`ifdef ICACHE_CRITICAL_WORD_EN
  logic r_crit_done;   // the missed fetch has already been answered

  assign w_crit_serve = w_take && fetch_valid && !r_crit_done &&
                        ({w_tag, w_idx} == r_base) && (r_cnt == w_off);

  always_ff @(posedge clk_in) begin
    if (rst_in || rob_clear) begin
      r_crit_done <= 1'b0;
    end else if (rdy_in) begin
      if (w_miss) begin
        r_crit_done <= 1'b0;
      end else if (w_crit_serve) begin
        r_crit_done <= 1'b1;
      end
    end
  end
`else
  assign w_crit_serve = 1'b0;
`endif

  assign fetch_ready = w_serve_hit || w_crit_serve;
  assign fetch_inst  = w_serve_hit  ? w_rd_word  :
                       w_crit_serve ? inst_result : 32'h0;

  // A flush wins over reset-free stalls: it always returns to IDLE.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_base  <= '0;
    end else if (rob_clear) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else if (rdy_in) begin
      case (r_state)
        ST_IDLE: begin
          if (w_miss) begin
            r_state <= ST_REFILL;
            r_base  <= {w_tag, w_idx};
            r_cnt   <= '0;
          end
        end
        ST_REFILL: begin
          if (w_take) begin
            r_cnt <= w_cnt_inc;
            if (w_last) begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_take) begin
      r_buf[r_cnt] <= inst_result;
    end
  end

endmodule : icache_fetch
`default_nettype wire

// File: tb/tb_icache_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_icache_fetch
//  Purpose  : Self-checking bench for icache_fetch. Acts as fetch stage and
//             memory interface; a line-level model of the cache (valid bit and
//             line base per index) predicts hit/miss and refill traffic.
//  Revision : 1.0  initial release
// ============================================================================
module tb_icache_fetch;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, rob_clear, fetch_valid, inst_ready;
  logic [31:0] fetch_addr, inst_result;
  logic        fetch_ready, inst_valid;
  logic [31:0] fetch_inst, inst_addr;

  int checks   = 0;
  int failures = 0;

  // Reference model: one entry per line index, holding the cached line base.
  bit          m_valid [64];
  logic [31:0] m_line  [64];

  icache_fetch dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .rdy_in      (rdy_in),
    .rob_clear   (rob_clear),
    .fetch_valid (fetch_valid),
    .fetch_addr  (fetch_addr),
    .fetch_ready (fetch_ready),
    .fetch_inst  (fetch_inst),
    .inst_valid  (inst_valid),
    .inst_addr   (inst_addr),
    .inst_ready  (inst_ready),
    .inst_result (inst_result)
  );

  always #5 clk_in = ~clk_in;

  // Memory contents: odd-multiplier hash keeps every word distinct.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h0BAD_F00D;
  endfunction

  function automatic logic [31:0] line_of(input logic [31:0] a);
    return a & 32'hFFFF_FFF0;
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 4) % 64);
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    return m_valid[idx_of(a)] && (m_line[idx_of(a)] == line_of(a));
  endfunction

  function automatic int pick_gap(input int gap);
    return (gap < 0) ? int'($urandom_range(0, 3)) : gap;
  endfunction

  // The fetch stage must keep its address while a refill is outstanding.
  logic        prev_iv = 1'b0;
  logic [31:0] prev_fa = 32'h0;
  always @(posedge clk_in) begin
    if (prev_iv && inst_valid && fetch_valid && !rob_clear)
      assert (fetch_addr == prev_fa) else $error("fetch_addr changed during refill");
    prev_iv <= inst_valid;
    prev_fa <= fetch_addr;
  end

  // One fetch from the fetch stage; memory answers with gaps and an optional
  // 2-cycle rdy_in stall before the word with offset 'rdylow_at'.
  task automatic run_fetch(input logic [31:0] addr, input int gap, input int rdylow_at);
    logic [31:0] base, expv;
    int k, wait_n, budget, off;
    bit served, rl_done;
    base = line_of(addr);
    off  = int'((addr >> 2) % 4);
    expv = mem_word(addr);
    rob_clear = 0; rdy_in = 1; inst_ready = 0; inst_result = $urandom;
    fetch_valid = 1; fetch_addr = addr;
    #1;
    if (model_hit(addr)) begin
      checks++;
      if (fetch_ready !== 1'b1 || fetch_inst !== expv) begin
        failures++;
        $display("FAIL hit_serve addr=%h: ready=%b inst=%h, expected ready=1 inst=%h",
                 addr, fetch_ready, fetch_inst, expv);
      end
      checks++;
      if (inst_valid !== 1'b0) begin
        failures++;
        $display("FAIL hit_no_request addr=%h: inst_valid=%b, expected 0", addr, inst_valid);
      end
      @(posedge clk_in); #1;
      fetch_valid = 0;
      return;
    end
    checks++;
    if (fetch_ready !== 1'b0 || inst_valid !== 1'b0) begin
      failures++;
      $display("FAIL miss_idle addr=%h: ready=%b inst_valid=%b, expected 0/0",
               addr, fetch_ready, inst_valid);
    end
    @(posedge clk_in); #1;
    k = 0; served = 0; rl_done = 0; budget = 0; wait_n = pick_gap(gap);
    while (k < 4 && budget < 400) begin
      budget++;
      inst_ready = 0; inst_result = $urandom;
      #1;
      checks++;
      if (inst_valid !== 1'b1 || inst_addr !== base + k * 4) begin
        failures++;
        $display("FAIL req_addr word %0d: valid=%b addr=%h, expected 1 %h",
                 k, inst_valid, inst_addr, base + k * 4);
      end
      if (!rl_done && k == rdylow_at) begin
        rl_done = 1; rdy_in = 0; inst_ready = 1;
        repeat (2) begin
          #1;
          checks++;
          if (fetch_ready !== 1'b0 || inst_valid !== 1'b1 || inst_addr !== base + k * 4) begin
            failures++;
            $display("FAIL rdy_low_hold: ready=%b valid=%b addr=%h, expected 0 1 %h",
                     fetch_ready, inst_valid, inst_addr, base + k * 4);
          end
          @(posedge clk_in); #1;
        end
        rdy_in = 1; inst_ready = 0;
        continue;
      end
      if (wait_n > 0) begin
        wait_n--;
        #1;
        checks++;
        if (fetch_ready !== 1'b0 || inst_valid !== 1'b1) begin
          failures++;
          $display("FAIL gap_hold: ready=%b valid=%b, expected 0 1", fetch_ready, inst_valid);
        end
      end else begin
        inst_ready = 1; inst_result = mem_word(base + k * 4);
        #1;
        if (k == 3) begin
          checks++;
          if (inst_valid !== 1'b0) begin
            failures++;
            $display("FAIL last_drop: inst_valid=%b, expected 0", inst_valid);
          end
        end else begin
          checks++;
          if (inst_valid !== 1'b1 || inst_addr !== base + (k + 1) * 4) begin
            failures++;
            $display("FAIL next_req word %0d: valid=%b addr=%h, expected 1 %h",
                     k, inst_valid, inst_addr, base + (k + 1) * 4);
          end
        end
`ifdef ICACHE_CRITICAL_WORD_EN
        if (k == off) begin
          checks++;
          if (fetch_ready !== 1'b1 || fetch_inst !== expv) begin
            failures++;
            $display("FAIL crit_serve: ready=%b inst=%h, expected 1 %h",
                     fetch_ready, fetch_inst, expv);
          end
          served = 1;
        end else begin
          checks++;
          if (fetch_ready !== 1'b0) begin
            failures++;
            $display("FAIL crit_other_word %0d: ready=%b, expected 0", k, fetch_ready);
          end
        end
`else
        checks++;
        if (fetch_ready !== 1'b0) begin
          failures++;
          $display("FAIL refill_ready word %0d (offset %0d): ready=%b, expected 0",
                   k, off, fetch_ready);
        end
`endif
        k++;
        wait_n = pick_gap(gap);
      end
      @(posedge clk_in); #1;
      if (served) fetch_valid = 0;
    end
    inst_ready = 0; inst_result = $urandom;
    checks++;
    if (k != 4) begin
      failures++;
      $display("FAIL refill_timeout: words=%0d, expected 4", k);
    end
    m_valid[idx_of(addr)] = 1;
    m_line[idx_of(addr)]  = base;
    #1;
`ifdef ICACHE_CRITICAL_WORD_EN
    checks++;
    if (inst_valid !== 1'b0 || fetch_ready !== 1'b0) begin
      failures++;
      $display("FAIL post_refill_idle: valid=%b ready=%b, expected 0 0", inst_valid, fetch_ready);
    end
`else
    checks++;
    if (fetch_ready !== 1'b1 || fetch_inst !== expv || inst_valid !== 1'b0) begin
      failures++;
      $display("FAIL post_refill_hit addr=%h: ready=%b inst=%h valid=%b, expected 1 %h 0",
               addr, fetch_ready, fetch_inst, inst_valid, expv);
    end
`endif
    @(posedge clk_in); #1;
    fetch_valid = 0;
  endtask

  // Miss on 'addr', accept 'nreq' words, then flush in a cycle that also
  // carries an inst_ready (and optionally rdy_in low).
  task automatic flush_fetch(input logic [31:0] addr, input int nreq, input logic clr_rdy);
    logic [31:0] base;
    base = line_of(addr);
    rob_clear = 0; rdy_in = 1; inst_ready = 0; fetch_valid = 1; fetch_addr = addr;
    #1;
    checks++;
    if (fetch_ready !== 1'b0) begin
      failures++;
      $display("FAIL flush_pre_miss addr=%h: ready=%b, expected 0", addr, fetch_ready);
    end
    @(posedge clk_in); #1;
    for (int k = 0; k < nreq; k++) begin
      inst_ready = 1; inst_result = mem_word(base + k * 4);
      @(posedge clk_in); #1;
    end
    inst_ready = 1; inst_result = mem_word(base + nreq * 4);
    rob_clear = 1; rdy_in = clr_rdy;
    #1;
    checks++;
    if (inst_valid !== 1'b0 || fetch_ready !== 1'b0) begin
      failures++;
      $display("FAIL clear_cycle after %0d words: valid=%b ready=%b, expected 0 0",
               nreq, inst_valid, fetch_ready);
    end
    @(posedge clk_in); #1;
    rob_clear = 0; rdy_in = 1; inst_ready = 0; fetch_valid = 0;
    #1;
    checks++;
    if (inst_valid !== 1'b0) begin
      failures++;
      $display("FAIL after_clear: inst_valid=%b, expected 0", inst_valid);
    end
    @(posedge clk_in); #1;
  endtask

  task automatic test_reset();
    rst_in = 1; rdy_in = 1; rob_clear = 0; fetch_valid = 0; fetch_addr = 0;
    inst_ready = 0; inst_result = 0;
    repeat (3) @(posedge clk_in);
    #1;
    checks++;
    if (fetch_ready !== 1'b0 || inst_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags: ready=%b valid=%b, expected 0 0", fetch_ready, inst_valid);
    end
    checks++;
    if (inst_addr !== 32'h0 || fetch_inst !== 32'h0) begin
      failures++;
      $display("FAIL reset_buses: inst_addr=%h fetch_inst=%h, expected 0 0", inst_addr, fetch_inst);
    end
    rst_in = 0;
    fetch_valid = 1; fetch_addr = 32'h0;
    #1;
    checks++;
    if (fetch_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_cold_line: ready=%b, expected 0", fetch_ready);
    end
    fetch_valid = 0;
    @(posedge clk_in); #1;
  endtask

  task automatic test_cold_miss();
    run_fetch(32'h0000_1004, 1, 9);
  endtask

  task automatic test_hit();
    run_fetch(32'h0000_100C, 0, 9);
  endtask

  task automatic test_conflict();
    run_fetch(32'h0000_1400, 0, 9);
    run_fetch(32'h0000_1000, 0, 9);
  endtask

  task automatic test_flush();
    flush_fetch(32'h0000_3000, 2, 1'b1);
    run_fetch(32'h0000_3000, 0, 9);
    flush_fetch(32'h0000_5014, 3, 1'b0);    // clear with last word and stall
    run_fetch(32'h0000_5018, 0, 9);
    // Flush during a would-be hit
    fetch_valid = 1; fetch_addr = 32'h0000_3004; rob_clear = 1;
    #1;
    checks++;
    if (fetch_ready !== 1'b0) begin
      failures++;
      $display("FAIL clear_blocks_hit: ready=%b, expected 0", fetch_ready);
    end
    @(posedge clk_in); #1;
    rob_clear = 0; fetch_valid = 0;
  endtask

  task automatic test_gaps();
    run_fetch(32'h0000_4010, 3, 1);
    fetch_valid = 1; fetch_addr = 32'h0000_4014; rdy_in = 0;
    #1;
    checks++;
    if (fetch_ready !== 1'b0) begin
      failures++;
      $display("FAIL stall_blocks_hit: ready=%b, expected 0", fetch_ready);
    end
    @(posedge clk_in); #1;
    rdy_in = 1; fetch_valid = 0;
  endtask

  task automatic test_critical_word();
    run_fetch(32'h0000_2008, 0, 9);
    run_fetch(32'h0000_2000, 0, 9);
  endtask

  task automatic test_back_to_back();
    run_fetch(32'h0000_4010, 0, 9);
    run_fetch(32'h0000_4014, 0, 9);
    run_fetch(32'h0000_3008, 0, 9);
    run_fetch(32'h0000_4018, 0, 9);
    run_fetch(32'h0000_401C, 0, 9);
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int i = 0; i < 80; i++) begin
      a = ($urandom_range(0, 2) << 10) | ($urandom_range(0, 3) << 4) |
          ($urandom_range(0, 3) << 2);
      if ($urandom_range(0, 5) == 0 && !model_hit(a))
        flush_fetch(a, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      else
        run_fetch(a, -1, int'($urandom_range(0, 7)));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk_in); #1;
      end
    end
  endtask

  initial begin
    #300000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_cold_miss();
    test_hit();
    test_conflict();
    test_flush();
    test_gaps();
    test_critical_word();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_icache_fetch
`default_nettype wire
